// File: rtl/reg_port_arbiter.sv
// Shares one register-file port between the SPI slave (req 0) and two status updaters (req 1/2).
// Ack comes 2 cycles after grant for writes, 2+RD_LATENCY for reads; requesters hold req until ack.
module reg_port_arbiter #(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [17:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  ack,
  output logic [7:0]  ack_rdata,
  output logic [5:0]  address,
  output logic        write_en,
  output logic [7:0]  wr_data,
  output logic        read_en,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, ACK} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [1:0] WAIT_LAST  = 2'(RD_LATENCY - 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       rr_pick2;
  logic [1:0] wait_cnt;
  logic       low_pending;
  logic [1:0] win;
  logic       win_we;
  logic [5:0] win_addr;
  logic [7:0] win_wdata;

  assign low_pending = req[1] | req[2];

  // Requester 0 normally wins; once it has starved 1/2 for STARVE_LIMIT grants, 1/2 get one turn.
  always_comb begin
    win = 2'd0;
    if (req[0] && !(low_pending && starve_cnt == STARVE_MAX)) win = 2'd0;
    else if (req[1] && req[2])                                win = rr_pick2 ? 2'd2 : 2'd1;
    else if (req[1])                                          win = 2'd1;
    else if (req[2])                                          win = 2'd2;
  end

  always_comb begin
    win_we    = req_we[0];
    win_addr  = req_addr[5:0];
    win_wdata = req_wdata[7:0];
    case (win)
      2'd1: begin
        win_we    = req_we[1];
        win_addr  = req_addr[11:6];
        win_wdata = req_wdata[15:8];
      end
      2'd2: begin
        win_we    = req_we[2];
        win_addr  = req_addr[17:12];
        win_wdata = req_wdata[23:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ack        <= 3'b000;
      ack_rdata  <= 8'h00;
      address    <= 6'h00;
      write_en   <= 1'b0;
      wr_data    <= 8'h00;
      read_en    <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 2'd0;
      starve_cnt <= 4'd0;
      rr_pick2   <= 1'b0;
      wait_cnt   <= 2'd0;
    end else begin
      ack      <= 3'b000;
      write_en <= 1'b0;
      read_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= win;
            address  <= win_addr;
            busy     <= 1'b1;
            if (win_we) begin
              wr_data  <= win_wdata;
              write_en <= 1'b1;
              state    <= WRITE;
            end else begin
              read_en <= 1'b1;
              state   <= READ;
            end
            if (win == 2'd0) begin
              if (low_pending && starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= 4'd0;
              rr_pick2   <= (win == 2'd1);
            end
          end
        end
        WRITE: begin
          ack   <= 3'b001 << grant_id;
          state <= ACK;
        end
        READ: begin
          wait_cnt <= WAIT_LAST;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            ack_rdata <= rd_data;
            ack       <= 3'b001 << grant_id;
            state     <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: per-requester driver, register-file model, and ack/write/read monitors
// fed from expectation queues that the directed sequence fills in hand-computed grant order.
module tb_reg_port_arbiter;

  localparam int RD_LATENCY   = 1;
  localparam int STARVE_LIMIT = 4;

  typedef struct { int id; logic we; logic [5:0] addr; logic [7:0] wdata; } stim_t;
  typedef struct { int id; logic rd; logic [7:0] rdata; int lat; } exp_t;
  typedef struct { int id; int cyc; } iss_t;
  typedef struct { logic [5:0] addr; logic [7:0] data; } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [17:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  ack;
  logic [7:0]  ack_rdata;
  logic [5:0]  address;
  logic        write_en;
  logic [7:0]  wr_data;
  logic        read_en;
  logic [7:0]  rd_data;
  logic        busy;
  logic [1:0]  grant_id;

  logic        mem_init = 1'b1;
  logic [7:0]  mem [64];
  logic [7:0]  rd_q;

  stim_t       stim_q[$];
  exp_t        sb_q[$];
  iss_t        iss_q[$];
  wr_t         wr_q[$];
  logic [5:0]  rda_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  reg_port_arbiter #(.RD_LATENCY(RD_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .ack_rdata(ack_rdata), .address(address),
    .write_en(write_en), .wr_data(wr_data), .read_en(read_en), .rd_data(rd_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Register file with a one-cycle registered read; cell a starts at a ^ 0x45.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'h45;
    end else if (write_en) begin
      mem[address] <= wr_data;
    end
    if (read_en) rd_q <= mem[address];
  end
  assign rd_data = rd_q;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int find_stim(int id);
    for (int k = 0; k < stim_q.size(); k++) if (stim_q[k].id == id) return k;
    return -1;
  endfunction

  function automatic int take_iss(int id);
    int r;
    for (int k = 0; k < iss_q.size(); k++) begin
      if (iss_q[k].id == id) begin
        r = iss_q[k].cyc;
        iss_q.delete(k);
        return r;
      end
    end
    return -1;
  endfunction

  // Driver: a requester presents its next queued request when idle, or on the edge it sees its ack.
  initial begin
    int    k;
    stim_t s;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || ack[i]) begin
          k = find_stim(i);
          if (k >= 0) begin
            s = stim_q[k];
            stim_q.delete(k);
            req[i]              = 1'b1;
            req_we[i]           = s.we;
            req_addr[6*i +: 6]  = s.addr;
            req_wdata[8*i +: 8] = s.wdata;
            iss_q.push_back('{i, cyc});
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every ack, write pulse and read pulse is matched against the expectation queues.
  initial begin
    exp_t       e;
    wr_t        w;
    int         iss;
    logic       prev_we = 1'b0;
    logic       prev_re = 1'b0;
    forever begin
      @(negedge clock);
      if (ack !== 3'b000) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 0);
        end else begin
          e   = sb_q.pop_front();
          iss = take_iss(e.id);
          chk("ack", 32'(ack), 32'(3'b001 << e.id));
          chk("ack_grant_id", 32'(grant_id), e.id);
          if (e.rd) chk("ack_rdata", 32'(ack_rdata), 32'(e.rdata));
          if (e.lat > 0) chk("latency", cyc - iss, e.lat);
        end
      end
      if (write_en) begin
        chk("wr_rd_exclusive", 32'(read_en), 0);
        chk("write_pulse_len", 32'(prev_we), 0);
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'(write_en), 0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_address", 32'(address), 32'(w.addr));
          chk("wr_data", 32'(wr_data), 32'(w.data));
        end
      end
      if (read_en) begin
        chk("read_pulse_len", 32'(prev_re), 0);
        if (rda_q.size() == 0) chk("unexpected_read", 32'(read_en), 0);
        else                   chk("rd_address", 32'(address), 32'(rda_q.pop_front()));
      end
      prev_we = write_en;
      prev_re = read_en;
    end
  end

  task automatic wr(int id, logic [5:0] a, logic [7:0] d, int lat);
    stim_q.push_back('{id, 1'b1, a, d});
    wr_q.push_back('{a, d});
    sb_q.push_back('{id, 1'b0, 8'h00, lat});
  endtask

  task automatic rd(int id, logic [5:0] a, logic [7:0] expd, int lat);
    stim_q.push_back('{id, 1'b0, a, 8'h00});
    rda_q.push_back(a);
    sb_q.push_back('{id, 1'b1, expd, lat});
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    @(negedge clock);
    while (!(stim_q.size() == 0 && sb_q.size() == 0 && req == 3'b000 && busy == 1'b0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: pending stim %0d acks %0d busy %b", tag, stim_q.size(), sb_q.size(), busy);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_write_en", 32'(write_en), 0);
    chk("rst_read_en", 32'(read_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_ack_rdata", 32'(ack_rdata), 0);
    reset    = 1'b0;
    mem_init = 1'b0;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 0);

    wr(0, 6'h05, 8'hA5, 2);
    wait_done("single_write");
    rd(1, 6'h10, 8'h55, 2 + RD_LATENCY);
    wait_done("single_read");
    wr(2, 6'h10, 8'h66, 2);
    wait_done("write_req2");
    chk("rdata_held_over_write", 32'(ack_rdata), 32'h55);

    // Requesters 1 and 2 both held: service alternates 1,2,1,2.
    rd(1, 6'h10, 8'h66, 0);
    wr(2, 6'h22, 8'h33, 0);
    wr(1, 6'h21, 8'h22, 0);
    rd(2, 6'h21, 8'h22, 0);
    wait_done("round_robin");

    // All three at once: 0 first, then round robin resumes at 1.
    wr(0, 6'h30, 8'h01, 2);
    rd(1, 6'h22, 8'h33, 0);
    rd(2, 6'h05, 8'hA5, 0);
    wait_done("all_three");

    // Requester 0 streaming with requester 1 waiting: 1 gets in after every 4th grant to 0.
    for (int k = 0; k < 4; k++) wr(0, 6'(6'h38 + k), 8'(8'h80 + k), 0);
    rd(1, 6'h30, 8'h01, 0);
    for (int k = 4; k < 8; k++) wr(0, 6'(6'h38 + k), 8'(8'h80 + k), 0);
    rd(1, 6'h38, 8'h80, 0);
    wait_done("starvation");

    // Reset during WAIT aborts the read; the still-held request completes afterwards.
    rd(2, 6'h11, 8'h54, 0);
    rda_q.push_back(6'h11);
    n = 0;
    while (read_en !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("abort_read_started", 32'(read_en), 1);
    @(negedge clock);
    chk("abort_busy_in_wait", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("abort_ack", 32'(ack), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_grant_id", 32'(grant_id), 0);
    chk("abort_address", 32'(address), 0);
    chk("abort_ack_rdata", 32'(ack_rdata), 0);
    chk("abort_read_en", 32'(read_en), 0);
    @(negedge clock);
    chk("abort_no_ack_in_reset", 32'(ack), 0);
    reset = 1'b0;
    wait_done("reset_abort");

    chk("left_acks", sb_q.size(), 0);
    chk("left_writes", wr_q.size(), 0);
    chk("left_reads", rda_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
